fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the instruction memory for the 16-bit MIPS core: owns the PC, issues word addresses,
//  and captures returned instructions into a 2-entry queue. It delivers instructions to decode over
//  a valid/ready handshake. Handles start, stall back-pressure, branch/jump redirect, halt request
//  and an end-of-program address. Sits between instruction_memory and the decode stage.
// PARAMETERS
//  ADDR_W    32    width of imem_addr / redirect_addr / instr_pc (byte-agnostic word index)
//  INSTR_W   32    instruction width returned by instruction memory
//  DEPTH     1024  instruction memory depth in words; PC index width IDX_W = $clog2(DEPTH)
//  RESET_PC  0     PC value after reset
//  LAST_ADDR 1023  final word index of the program; fetching stops after it is issued
// PORTS
//  clk           in   1        clock, all state on rising edge
//  reset         in   1        asynchronous, active-high reset
//  start         in   1        begin fetching at current PC (honoured in IDLE only)
//  imem_en       out  1        read strobe to instruction memory
//  imem_addr     out  ADDR_W   word address to instruction memory (upper bits zero)
//  imem_rdata    in   INSTR_W  read data, valid the cycle after imem_en/imem_addr sampled
//  instr_valid   out  1        instr_out/instr_pc hold a valid instruction
//  instr_ready   in   1        decode accepts; transfer when valid && ready
//  instr_out     out  INSTR_W  fetched instruction
//  instr_pc      out  ADDR_W   word address of instr_out
//  redirect_valid in  1        one-cycle pulse: branch/jump taken
//  redirect_addr in   ADDR_W   redirect target word address
//  halt_req      in   1        stop fetching immediately and discard pending work
//  halted        out  1        state == HALT
//  addr_err      out  1        sticky: a redirect target had bits [ADDR_W-1:IDX_W] nonzero
// BEHAVIOUR
//  - Reset (any time, mid-fetch included): state=IDLE, pc=RESET_PC, queue empty, in-flight cleared,
//    imem_en=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, halted=0, addr_err=0.
//  - States: IDLE -start-> RUN; RUN -issue of LAST_ADDR-> DRAIN; DRAIN -queue empty & none in flight-> HALT;
//    RUN/DRAIN -halt_req-> HALT; HALT -redirect_valid-> RUN at target; IDLE ignores redirect/halt_req.
//  - Issue (RUN only): imem_en=1, imem_addr=pc when occupancy + in_flight - pop < 2, where pop = valid&&ready.
//    On issue pc <= (pc==DEPTH-1) ? 0 : pc+1 (wrap). Sustains 1 instruction/cycle while instr_ready=1.
//  - Response: in_flight set on issue; next cycle imem_rdata and issued pc pushed to queue unless squashed.
//  - Latency: start sampled at edge N -> imem_en at cycle N+1 -> instr_valid (pc 0) at cycle N+3.
//  - Queue: 2 entries, FIFO order; head drives instr_out/instr_pc; never overflows by issue rule;
//    simultaneous push and pop on a full queue is legal; instr_out stable while valid && !ready.
//  - Redirect (RUN/DRAIN/HALT): at that edge queue flushed, in-flight response squashed (epoch bit
//    toggled, stale data dropped), pc <= redirect_addr[IDX_W-1:0], state RUN; first issue the cycle
//    after. Upper-bit violation sets addr_err, low bits still used. Redirect beats halt_req beats start.
//  - halt_req: queue flushed, in-flight squashed, imem_en=0 from next cycle, halted=1.
//  - LAST_ADDR issued: no further issue; remaining queued instructions still delivered, then HALT.
// STRUCTURE
//  - Shared package mips16_pkg: fetch state encoding (IDLE/RUN/DRAIN/HALT), ADDR_W/INSTR_W defaults,
//    DEPTH=1024 constant.
//  - One sub-module: fetch_queue (2-entry sync FIFO with flush, {instr,pc} payload, count output).
//  - Top holds FSM, PC, in-flight/epoch flags, issue credit logic.
// TESTING
//  - Reset then start, instr_ready=1, memory preloaded with word i = i: imem_addr 0,1,2,...
//    consecutive cycles; instr_valid from 3 cycles after start, instr_out=instr_pc=0,1,2 back to back.
//  - Hold instr_ready=0 for 5 cycles after first valid: exactly 2 addresses outstanding; instr_out stays 0;
//    on release words 0,1,2 delivered in order, none lost or duplicated.
//  - Redirect to 12 while word 5 in flight and words 3,4 queued: 3,4,5 never delivered; next valid
//    instr_pc=12, then 13; redirect_addr=0x400 sets addr_err=1 and fetches index 0.
//  - LAST_ADDR=4: addresses 0..4 issued only; five instructions delivered, then halted=1, imem_en=0.
//  - halt_req during stream: instr_valid drops next cycle, halted=1; redirect to 7 resumes with pc 7.
//  - Assert reset mid-stream (async, between edges): all outputs zero immediately; restart yields pc 0.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS core front end: fetch state encoding and default widths.
package mips16_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int IMEM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory, decode-handshake and redirect signals shared by fetch and its neighbours.
interface fetch_controller_if
    import mips16_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;

    modport master (
        output imem_en, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_rdata, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  imem_en, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_rdata, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding {instr, pc} pairs between instruction memory and decode.
module fetch_queue #(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Flush wins over a same-cycle push so a squashed response never lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues imem reads under a 2-slot credit, and feeds decode from fetch_queue.
module fetch_controller
    import mips16_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int RESET_PC  = 0,
    parameter int LAST_ADDR = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    output logic              halted,
    output logic              addr_err,
    fetch_controller_if.master bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int Q_W   = INSTR_W + IDX_W;
    localparam logic [IDX_W-1:0] PC_MAX   = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_ADDR);
    localparam logic [IDX_W-1:0] PC_INIT  = IDX_W'(RESET_PC);

    fetch_state_e     state;
    logic [IDX_W-1:0] pc;
    logic [IDX_W-1:0] flight_pc;
    logic             in_flight;
    logic             flight_epoch;
    logic             epoch;
    logic [1:0]       count;
    logic [Q_W-1:0]   head;
    logic             pop;
    logic             issue;
    logic             push;
    logic             redirect_take;
    logic             halt_take;
    logic             squash;
    logic             last_issue;

    assign bus.instr_valid = (count != 2'd0);
    assign pop             = bus.instr_valid && bus.instr_ready;

    // Queued plus outstanding entries, less the one leaving this cycle, must leave a free slot.
    assign issue = (state == ST_RUN) &&
                   (({1'b0, count} + {2'b00, in_flight} - {2'b00, pop}) < 3'd2);

    assign redirect_take = bus.redirect_valid && (state != ST_IDLE);
    assign halt_take     = halt_req && !redirect_take &&
                           ((state == ST_RUN) || (state == ST_DRAIN));
    assign squash        = redirect_take || halt_take;
    assign push          = in_flight && (flight_epoch == epoch) && !squash;
    assign last_issue    = issue && (pc == LAST_IDX);

    assign bus.imem_en   = issue;
    assign bus.imem_addr = {{(ADDR_W - IDX_W){1'b0}}, pc};
    assign bus.instr_out = head[Q_W-1:IDX_W];
    assign bus.instr_pc  = {{(ADDR_W - IDX_W){1'b0}}, head[IDX_W-1:0]};
    assign halted        = (state == ST_HALT);

    fetch_queue #(.W(Q_W)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (squash),
        .push      (push),
        .push_data ({bus.imem_rdata, flight_pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Epoch toggles on every squash so a response issued before it can never be queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pc           <= PC_INIT;
            flight_pc    <= '0;
            in_flight    <= 1'b0;
            flight_epoch <= 1'b0;
            epoch        <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            in_flight <= issue && !squash;
            if (issue) begin
                flight_pc    <= pc;
                flight_epoch <= epoch;
            end
            if (redirect_take) begin
                epoch <= ~epoch;
                pc    <= bus.redirect_addr[IDX_W-1:0];
                state <= ST_RUN;
                if (|bus.redirect_addr[ADDR_W-1:IDX_W]) begin
                    addr_err <= 1'b1;
                end
            end else if (halt_take) begin
                epoch <= ~epoch;
                state <= ST_HALT;
            end else begin
                if (issue) begin
                    pc <= (pc == PC_MAX) ? '0 : pc + IDX_W'(1);
                end
                case (state)
                    ST_IDLE:  if (start) state <= ST_RUN;
                    ST_RUN:   if (last_issue) state <= ST_DRAIN;
                    ST_DRAIN: if ((count == 2'd0) && !in_flight) state <= ST_HALT;
                    default:  state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected instruction stream queued at start/redirect, checked on delivery.
module tb_fetch_controller;
    import mips16_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic halted;
    logic addr_err;
    logic start2 = 1'b0;
    logic halt_req2 = 1'b0;
    logic halted2;
    logic addr_err2;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_q2[$];
    int issue_cnt = 0;
    int issue_cnt2 = 0;
    int max_addr2 = 0;

    fetch_controller_if bus ();
    fetch_controller_if bus2 ();

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt_req (halt_req),
        .halted   (halted),
        .addr_err (addr_err),
        .bus      (bus)
    );

    fetch_controller #(.LAST_ADDR(4)) dut_last (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .halt_req (halt_req2),
        .halted   (halted2),
        .addr_err (addr_err2),
        .bus      (bus2)
    );

    // Instruction memory preloaded with word i = i, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_en)  bus.imem_rdata  <= bus.imem_addr;
        if (bus2.imem_en) bus2.imem_rdata <= bus2.imem_addr;
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_expected(input int first, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back((first + i) % IMEM_DEPTH);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.instr_valid && n < budget) begin
            tick();
            n++;
        end
        check_output(tag, 64'(bus.instr_valid), 64'd1);
    endtask

    // Each accepted transfer must match the head of the expected stream.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_en) issue_cnt++;
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("extra_delivery", 64'd1, 64'd0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check_output("instr_pc", 64'(bus.instr_pc), 64'(e));
                    check_output("instr_out", 64'(bus.instr_out), 64'(e));
                end
            end
            if (bus2.imem_en) begin
                issue_cnt2++;
                if (int'(bus2.imem_addr) > max_addr2) max_addr2 = int'(bus2.imem_addr);
            end
            if (bus2.instr_valid && bus2.instr_ready) begin
                if (exp_q2.size() == 0) begin
                    check_output("last_extra_delivery", 64'd1, 64'd0);
                end else begin
                    int e2;
                    e2 = exp_q2.pop_front();
                    check_output("last_instr_pc", 64'(bus2.instr_pc), 64'(e2));
                end
            end
        end
    end

    initial begin
        #100000;
        check_output("global_timeout", 64'd0, 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_addr   = '0;
        bus2.instr_ready    = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_addr  = '0;
        #1;
        check_output("rst_imem_en", 64'(bus.imem_en), 64'd0);
        check_output("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check_output("rst_valid", 64'(bus.instr_valid), 64'd0);
        check_output("rst_instr_out", 64'(bus.instr_out), 64'd0);
        check_output("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
        check_output("rst_halted", 64'(halted), 64'd0);
        check_output("rst_addr_err", 64'(addr_err), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Streaming with decode always ready
        bus.instr_ready = 1'b1;
        load_expected(0, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("lat_en_n1", 64'(bus.imem_en), 64'd1);
        check_output("lat_addr_n1", 64'(bus.imem_addr), 64'd0);
        check_output("lat_valid_n1", 64'(bus.instr_valid), 64'd0);
        tick();
        check_output("lat_addr_n2", 64'(bus.imem_addr), 64'd1);
        check_output("lat_valid_n2", 64'(bus.instr_valid), 64'd0);
        tick();
        check_output("lat_valid_n3", 64'(bus.instr_valid), 64'd1);
        check_output("lat_pc_n3", 64'(bus.instr_pc), 64'd0);
        check_output("lat_addr_n3", 64'(bus.imem_addr), 64'd2);
        repeat (8) tick();

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check_output("async_rst_valid", 64'(bus.instr_valid), 64'd0);
        check_output("async_rst_en", 64'(bus.imem_en), 64'd0);
        check_output("async_rst_addr", 64'(bus.imem_addr), 64'd0);
        check_output("async_rst_pc", 64'(bus.instr_pc), 64'd0);
        check_output("async_rst_out", 64'(bus.instr_out), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();

        // Back-pressure: decode stalls from the first valid
        bus.instr_ready = 1'b0;
        load_expected(0, 200);
        issue_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, "stall_first_valid");
        for (int i = 0; i < 5; i++) begin
            check_output("stall_instr_out", 64'(bus.instr_out), 64'd0);
            check_output("stall_valid", 64'(bus.instr_valid), 64'd1);
            tick();
        end
        check_output("stall_outstanding", 64'(issue_cnt), 64'd2);
        bus.instr_ready = 1'b1;
        repeat (6) tick();

        // Redirect to 12 with the queue full
        bus.instr_ready = 1'b0;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'd12;
        load_expected(12, 100);
        tick();
        bus.redirect_valid = 1'b0;
        check_output("redirect_flush", 64'(bus.instr_valid), 64'd0);
        bus.instr_ready = 1'b1;
        wait_valid(10, "redirect_valid");
        check_output("redirect_first_pc", 64'(bus.instr_pc), 64'd12);
        repeat (5) tick();

        // Out-of-range redirect target
        check_output("addr_err_clear", 64'(addr_err), 64'd0);
        bus.instr_ready = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h400;
        load_expected(0, 100);
        tick();
        bus.redirect_valid = 1'b0;
        check_output("addr_err_set", 64'(addr_err), 64'd1);
        bus.instr_ready = 1'b1;
        wait_valid(10, "addr_err_valid");
        check_output("addr_err_pc", 64'(bus.instr_pc), 64'd0);
        repeat (4) tick();

        // Halt mid-stream, then resume by redirect
        bus.instr_ready = 1'b0;
        halt_req = 1'b1;
        exp_q.delete();
        tick();
        halt_req = 1'b0;
        check_output("halt_valid", 64'(bus.instr_valid), 64'd0);
        check_output("halt_halted", 64'(halted), 64'd1);
        check_output("halt_en", 64'(bus.imem_en), 64'd0);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("halt_hold_en", 64'(bus.imem_en), 64'd0);
        end
        load_expected(7, 100);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'd7;
        tick();
        bus.redirect_valid = 1'b0;
        check_output("resume_halted", 64'(halted), 64'd0);
        wait_valid(10, "resume_valid");
        check_output("resume_pc", 64'(bus.instr_pc), 64'd7);
        repeat (5) tick();

        // End-of-program at LAST_ADDR=4
        exp_q2.delete();
        for (int i = 0; i < 5; i++) exp_q2.push_back(i);
        issue_cnt2 = 0;
        max_addr2  = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 0; n < 30 && !halted2; n++) tick();
        check_output("last_halted", 64'(halted2), 64'd1);
        check_output("last_en", 64'(bus2.imem_en), 64'd0);
        check_output("last_issue_count", 64'(issue_cnt2), 64'd5);
        check_output("last_max_addr", 64'(max_addr2), 64'd4);
        check_output("last_remaining", 64'(exp_q2.size()), 64'd0);
        repeat (3) tick();
        check_output("last_valid_after", 64'(bus2.instr_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
